// File: rtl/axi_mem_slave_pkg.sv
// Shared definitions for the AXI memory responder: response codes and FSM encodings.
package axi_mem_slave_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 INCR-only bus bundle (AW, W, B, AR, R) between a master and the memory responder.
interface axi_mem_slave_if #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
);
    logic                        axi_awvalid;
    logic                        axi_awready;
    logic [AXI_ID_WIDTH-1:0]     axi_awid;
    logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
    logic [AXI_LEN_WIDTH-1:0]    axi_awlen;

    logic                        axi_wvalid;
    logic                        axi_wready;
    logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
    logic                        axi_wlast;

    logic                        axi_bvalid;
    logic                        axi_bready;
    logic [AXI_ID_WIDTH-1:0]     axi_bid;
    logic [1:0]                  axi_bresp;

    logic                        axi_arvalid;
    logic                        axi_arready;
    logic [AXI_ID_WIDTH-1:0]     axi_arid;
    logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
    logic [AXI_LEN_WIDTH-1:0]    axi_arlen;

    logic                        axi_rvalid;
    logic                        axi_rready;
    logic [AXI_ID_WIDTH-1:0]     axi_rid;
    logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
    logic [1:0]                  axi_rresp;
    logic                        axi_rlast;

    modport master (
        output axi_awvalid, axi_awid, axi_awaddr, axi_awlen,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_bready,
        output axi_arvalid, axi_arid, axi_araddr, axi_arlen,
        output axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
        input  axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
    );

    modport slave (
        input  axi_awvalid, axi_awid, axi_awaddr, axi_awlen,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_bready,
        input  axi_arvalid, axi_arid, axi_araddr, axi_arlen,
        input  axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
        output axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
    );

endinterface

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, read-first, no reset.
module axi_mem_ram #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 256
) (
    input  logic                clk,
    input  logic [DWIDTH/8-1:0] wr_be_i,
    input  logic [AWIDTH-1:0]   wr_addr_i,
    input  logic [DWIDTH-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [AWIDTH-1:0]   rd_addr_i,
    output logic [DWIDTH-1:0]   rd_data_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rd_data_q;

    // Byte-lane writes; each lane updates only when its enable is set.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DWIDTH/8; b++) begin
            if (wr_be_i[b]) mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
    end

    // Registered read; a same-cycle write to the same word is not visible (old data returned).
    always_ff @(posedge clk) begin
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory responder: independent write and read FSMs over a dual-port RAM,
// with a 2-entry output buffer on R so that a stalled master never loses or repeats a beat.
//
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting exactly awlen+1 beats
//   W_RESP | bvalid high, holding bresp/bid until bready
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | issuing RAM reads and draining the output buffer until the rlast handshake
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int MEM_AWIDTH     = 10,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
) (
    input logic            clk,
    input logic            rst,
    axi_mem_slave_if.slave axi
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);

    logic en_q;

    logic [1:0]               wst_q, wst_d;
    logic [MEM_AWIDTH-1:0]    widx_q, widx_d;
    logic [AXI_LEN_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [AXI_ID_WIDTH-1:0]  bid_q, bid_d;
    logic                     werr_q, werr_d;

    logic [0:0]               rd_st_q, rd_st_d;
    logic [MEM_AWIDTH-1:0]    ridx_q, ridx_d;
    logic [AXI_LEN_WIDTH-1:0] rcnt_q, rcnt_d;
    logic [AXI_ID_WIDTH-1:0]  rid_q, rid_d;
    logic                     rdone_q, rdone_d;

    logic                      ram_vld_q, ram_last_q;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;

    logic [AXI_DATA_WIDTH-1:0] fd_q [2];
    logic                      fl_q [2];
    logic                      fwp_q, frp_q;
    logic [1:0]                fcnt_q;
    logic [1:0]                occ;

    logic aw_hs, w_hs, b_hs, ar_hs, r_pop, issue, head_last;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{axi.axi_awaddr, axi.axi_araddr};

    // Readies stay low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= 1'b1;
    end

    assign axi.axi_awready = en_q && (wst_q == W_IDLE);
    assign axi.axi_wready  = (wst_q == W_DATA);
    assign axi.axi_bvalid  = (wst_q == W_RESP);
    assign axi.axi_bid     = bid_q;
    assign axi.axi_bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs = axi.axi_awvalid && axi.axi_awready;
    assign w_hs  = axi.axi_wvalid && axi.axi_wready;
    assign b_hs  = axi.axi_bvalid && axi.axi_bready;

    // Write FSM next state: latch AW, count beats, flag any misplaced wlast.
    always_comb begin
        wst_d  = wst_q;
        widx_d = widx_q;
        wcnt_d = wcnt_q;
        bid_d  = bid_q;
        werr_d = werr_q;
        case (wst_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wst_d  = W_DATA;
                    widx_d = axi.axi_awaddr[OFFS +: MEM_AWIDTH];
                    wcnt_d = axi.axi_awlen;
                    bid_d  = axi.axi_awid;
                    werr_d = 1'b0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    widx_d = widx_q + 1'b1;
                    wcnt_d = wcnt_q - 1'b1;
                    if (axi.axi_wlast != (wcnt_q == '0)) werr_d = 1'b1;
                    if (wcnt_q == '0) wst_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) wst_d = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Write FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q  <= W_IDLE;
            widx_q <= '0;
            wcnt_q <= '0;
            bid_q  <= '0;
            werr_q <= 1'b0;
        end else begin
            wst_q  <= wst_d;
            widx_q <= widx_d;
            wcnt_q <= wcnt_d;
            bid_q  <= bid_d;
            werr_q <= werr_d;
        end
    end

    // Every issued beat holds a buffer slot until popped; a same-cycle pop frees one,
    // which keeps back-to-back beats flowing with only two slots.
    assign occ       = fcnt_q + {1'b0, ram_vld_q};
    assign r_pop     = axi.axi_rvalid && axi.axi_rready;
    assign head_last = fl_q[frp_q];
    assign issue     = (rd_st_q == R_DATA) && !rdone_q && ((occ < 2'd2) || r_pop);

    assign axi.axi_arready = en_q && (rd_st_q == R_IDLE);
    assign axi.axi_rvalid  = (fcnt_q != 2'd0);
    assign axi.axi_rdata   = axi.axi_rvalid ? fd_q[frp_q] : '0;
    assign axi.axi_rlast   = axi.axi_rvalid && head_last;
    assign axi.axi_rid     = rid_q;
    assign axi.axi_rresp   = RESP_OKAY;

    assign ar_hs = axi.axi_arvalid && axi.axi_arready;

    // Read FSM next state: latch AR, step the issue pointer, leave on the rlast handshake.
    always_comb begin
        rd_st_d = rd_st_q;
        ridx_d  = ridx_q;
        rcnt_d  = rcnt_q;
        rid_d   = rid_q;
        rdone_d = rdone_q;
        if (rd_st_q == R_IDLE) begin
            if (ar_hs) begin
                rd_st_d = R_DATA;
                ridx_d  = axi.axi_araddr[OFFS +: MEM_AWIDTH];
                rcnt_d  = axi.axi_arlen;
                rid_d   = axi.axi_arid;
                rdone_d = 1'b0;
            end
        end else begin
            if (issue) begin
                ridx_d = ridx_q + 1'b1;
                rcnt_d = rcnt_q - 1'b1;
                if (rcnt_q == '0) rdone_d = 1'b1;
            end
            if (r_pop && head_last) rd_st_d = R_IDLE;
        end
    end

    // Read FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st_q <= R_IDLE;
            ridx_q  <= '0;
            rcnt_q  <= '0;
            rid_q   <= '0;
            rdone_q <= 1'b0;
        end else begin
            rd_st_q <= rd_st_d;
            ridx_q  <= ridx_d;
            rcnt_q  <= rcnt_d;
            rid_q   <= rid_d;
            rdone_q <= rdone_d;
        end
    end

    // Tracks which RAM output word is a live beat, and whether it is the burst's last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_vld_q  <= 1'b0;
            ram_last_q <= 1'b0;
        end else begin
            ram_vld_q  <= issue;
            ram_last_q <= (rcnt_q == '0);
        end
    end

    // Output buffer pointers and fill count; reset empties it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp_q  <= 1'b0;
            frp_q  <= 1'b0;
            fcnt_q <= 2'd0;
        end else begin
            if (ram_vld_q) fwp_q <= ~fwp_q;
            if (r_pop)     frp_q <= ~frp_q;
            fcnt_q <= fcnt_q + {1'b0, ram_vld_q} - {1'b0, r_pop};
        end
    end

    // Output buffer storage; contents are masked at the port while empty.
    always_ff @(posedge clk) begin
        if (ram_vld_q) begin
            fd_q[fwp_q] <= ram_rdata;
            fl_q[fwp_q] <= ram_last_q;
        end
    end

    axi_mem_ram #(
        .AWIDTH (MEM_AWIDTH),
        .DWIDTH (AXI_DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_be_i   (w_hs ? axi.axi_wstrb : '0),
        .wr_addr_i (widx_q),
        .wr_data_i (axi.axi_wdata),
        .rd_en_i   (issue),
        .rd_addr_i (ridx_q),
        .rd_data_o (ram_rdata)
    );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: drives and samples on the falling edge.
module tb_axi_mem_slave;
    import axi_mem_slave_pkg::*;

    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] rdat [16];
    logic          rlst [16];
    int            rids [16];
    int            rcyc;

    axi_mem_slave_if axi ();

    axi_mem_slave dut (
        .clk (clk),
        .rst (rst),
        .axi (axi)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic aw(input logic [31:0] a, input logic [7:0] l, input logic [7:0] id);
        int n = 0;
        axi.axi_awvalid = 1'b1; axi.axi_awaddr = a; axi.axi_awlen = l; axi.axi_awid = id;
        while (!axi.axi_awready && n < 100) begin @(negedge clk); n++; end
        chk_b("aw_wait", n < 100, 1'b1);
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] l, input logic [7:0] id);
        int n = 0;
        axi.axi_arvalid = 1'b1; axi.axi_araddr = a; axi.axi_arlen = l; axi.axi_arid = id;
        while (!axi.axi_arready && n < 100) begin @(negedge clk); n++; end
        chk_b("ar_wait", n < 100, 1'b1);
        @(negedge clk);
        axi.axi_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [DW-1:0] d, input logic [31:0] s, input logic l);
        int n = 0;
        axi.axi_wvalid = 1'b1; axi.axi_wdata = d; axi.axi_wstrb = s; axi.axi_wlast = l;
        while (!axi.axi_wready && n < 100) begin @(negedge clk); n++; end
        chk_b("w_wait", n < 100, 1'b1);
        @(negedge clk);
        axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0;
    endtask

    task automatic b_take(input int exp_resp, input int exp_id, input string tag);
        int n = 0;
        axi.axi_bready = 1'b1;
        while (!axi.axi_bvalid && n < 100) begin @(negedge clk); n++; end
        chk_b({tag, "_bvalid"}, axi.axi_bvalid, 1'b1);
        chk_n({tag, "_bresp"}, int'(axi.axi_bresp), exp_resp);
        chk_n({tag, "_bid"}, int'(axi.axi_bid), exp_id);
        @(negedge clk);
        axi.axi_bready = 1'b0;
        chk_b({tag, "_awready_back"}, axi.axi_awready, 1'b1);
    endtask

    // Collects len+1 beats with rready following pat (bit 0 first), checking hold during stalls.
    task automatic rd_burst(input int len, input logic [3:0] pat);
        int cyc = 0;
        int nb = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] hd = '0;
        logic hl = 1'b0;
        while (nb <= len && cyc < 200) begin
            axi.axi_rready = pat[cyc % 4];
            if (stalled) begin
                chk_b("stall_rvalid", axi.axi_rvalid, 1'b1);
                chk_v("stall_rdata", axi.axi_rdata, hd);
                chk_b("stall_rlast", axi.axi_rlast, hl);
            end
            if (axi.axi_rvalid && axi.axi_rready) begin
                rdat[nb] = axi.axi_rdata; rlst[nb] = axi.axi_rlast; rids[nb] = int'(axi.axi_rid);
                nb++;
                stalled = 1'b0;
            end else if (axi.axi_rvalid) begin
                stalled = 1'b1; hd = axi.axi_rdata; hl = axi.axi_rlast;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        axi.axi_rready = 1'b0;
        rcyc = cyc;
        chk_n("rd_beats", nb, len + 1);
        chk_b("rd_end_rvalid", axi.axi_rvalid, 1'b0);
        chk_b("rd_end_arready", axi.axi_arready, 1'b1);
    endtask

    initial begin
        int n;
        axi.axi_awvalid = 0; axi.axi_awid = 0; axi.axi_awaddr = 0; axi.axi_awlen = 0;
        axi.axi_wvalid = 0; axi.axi_wdata = 0; axi.axi_wstrb = 0; axi.axi_wlast = 0;
        axi.axi_bready = 0;
        axi.axi_arvalid = 0; axi.axi_arid = 0; axi.axi_araddr = 0; axi.axi_arlen = 0;
        axi.axi_rready = 0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk_b("rst_awready", axi.axi_awready, 1'b0);
        chk_b("rst_wready", axi.axi_wready, 1'b0);
        chk_b("rst_bvalid", axi.axi_bvalid, 1'b0);
        chk_b("rst_arready", axi.axi_arready, 1'b0);
        chk_b("rst_rvalid", axi.axi_rvalid, 1'b0);
        chk_b("rst_rlast", axi.axi_rlast, 1'b0);
        chk_v("rst_rdata", axi.axi_rdata, '0);
        chk_n("rst_bresp", int'(axi.axi_bresp), 0);
        chk_n("rst_bid", int'(axi.axi_bid), 0);
        chk_n("rst_rid", int'(axi.axi_rid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_b("post_rst_awready", axi.axi_awready, 1'b1);
        chk_b("post_rst_arready", axi.axi_arready, 1'b1);

        // 4-beat write then read at 0x40
        aw(32'h40, 8'd3, 8'h5A);
        for (int i = 0; i < 4; i++) w_beat(256'(i + 1), '1, i == 3);
        chk_b("w4_wready_done", axi.axi_wready, 1'b0);
        b_take(int'(RESP_OKAY), 'h5A, "b4");
        ar(32'h40, 8'd3, 8'hA5);
        chk_b("lat_c0", axi.axi_rvalid, 1'b0);
        @(negedge clk);
        chk_b("lat_c1", axi.axi_rvalid, 1'b0);
        @(negedge clk);
        chk_b("lat_c2", axi.axi_rvalid, 1'b1);
        rd_burst(3, 4'b1111);
        chk_n("r4_nobubble", rcyc, 4);
        for (int i = 0; i < 4; i++) begin
            chk_v("r4_data", rdat[i], 256'(i + 1));
            chk_b("r4_last", rlst[i], i == 3);
            chk_n("r4_rid", rids[i], 'hA5);
        end

        // Partial strobe over an all-ones word
        aw(32'h140, 8'd0, 8'h01);
        w_beat('1, '1, 1'b1);
        b_take(int'(RESP_OKAY), 'h01, "bones");
        aw(32'h140, 8'd0, 8'h02);
        w_beat('0, 32'h0000_000F, 1'b1);
        b_take(int'(RESP_OKAY), 'h02, "bstrb");
        ar(32'h140, 8'd0, 8'h03);
        rd_burst(0, 4'b1111);
        chk_v("strb_data", rdat[0], {{28{8'hFF}}, 32'h0});
        chk_b("strb_last", rlst[0], 1'b1);

        // 8-beat read with rready 1,0,0,1
        aw(32'h400, 8'd7, 8'h07);
        for (int i = 0; i < 8; i++) w_beat(256'(256 + i), '1, i == 7);
        b_take(int'(RESP_OKAY), 'h07, "b8");
        ar(32'h400, 8'd7, 8'h39);
        rd_burst(7, 4'b1001);
        for (int i = 0; i < 8; i++) begin
            chk_v("r8_data", rdat[i], 256'(256 + i));
            chk_b("r8_last", rlst[i], i == 7);
        end

        // Wrap at memory top, early wlast -> SLVERR
        aw(32'h7FE0, 8'd1, 8'h40);
        w_beat(256'hAA, '1, 1'b1);
        w_beat(256'hBB, '1, 1'b1);
        chk_b("wrap_wready_done", axi.axi_wready, 1'b0);
        b_take(int'(RESP_SLVERR), 'h40, "bwrap");
        ar(32'h0, 8'd0, 8'h11);
        rd_burst(0, 4'b1111);
        chk_v("wrap_word0", rdat[0], 256'hBB);
        ar(32'h7FE0, 8'd1, 8'h12);
        rd_burst(1, 4'b1111);
        chk_v("wrap_r0", rdat[0], 256'hAA);
        chk_v("wrap_r1", rdat[1], 256'hBB);
        chk_b("wrap_last0", rlst[0], 1'b0);
        chk_b("wrap_last1", rlst[1], 1'b1);

        // Concurrent AR/AW to one word, W in the cycle of the first RAM read
        aw(32'h640, 8'd0, 8'h41);
        w_beat(256'h1111, '1, 1'b1);
        b_take(int'(RESP_OKAY), 'h41, "bold");
        axi.axi_awvalid = 1'b1; axi.axi_awaddr = 32'h640; axi.axi_awlen = 8'd0; axi.axi_awid = 8'h42;
        axi.axi_arvalid = 1'b1; axi.axi_araddr = 32'h640; axi.axi_arlen = 8'd0; axi.axi_arid = 8'h43;
        chk_b("sim_awready", axi.axi_awready, 1'b1);
        chk_b("sim_arready", axi.axi_arready, 1'b1);
        @(negedge clk);
        axi.axi_awvalid = 1'b0; axi.axi_arvalid = 1'b0;
        axi.axi_wvalid = 1'b1; axi.axi_wdata = 256'h2222; axi.axi_wstrb = '1; axi.axi_wlast = 1'b1;
        chk_b("sim_wready", axi.axi_wready, 1'b1);
        @(negedge clk);
        axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0;
        b_take(int'(RESP_OKAY), 'h42, "bnew");
        rd_burst(0, 4'b1111);
        chk_v("rfirst_old", rdat[0], 256'h1111);
        chk_n("rfirst_rid", rids[0], 'h43);
        ar(32'h640, 8'd0, 8'h44);
        rd_burst(0, 4'b1111);
        chk_v("rfirst_new", rdat[0], 256'h2222);

        // Reset during beat 2 of an 8-beat read
        ar(32'h400, 8'd7, 8'h55);
        axi.axi_rready = 1'b1;
        n = 0;
        while (!(axi.axi_rvalid && axi.axi_rdata == 256'h102) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_b("mid_beat2_seen", n < 50, 1'b1);
        rst = 1'b1;
        #1;
        chk_b("mid_rst_rvalid", axi.axi_rvalid, 1'b0);
        chk_b("mid_rst_arready", axi.axi_arready, 1'b0);
        chk_b("mid_rst_awready", axi.axi_awready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        axi.axi_rready = 1'b0;
        @(negedge clk);
        chk_b("mid_rel_arready", axi.axi_arready, 1'b1);
        chk_b("mid_rel_rvalid", axi.axi_rvalid, 1'b0);
        ar(32'h400, 8'd7, 8'h56);
        rd_burst(7, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            chk_v("post_rst_data", rdat[i], 256'(256 + i));
            chk_b("post_rst_last", rlst[i], i == 7);
            chk_n("post_rst_rid", rids[i], 'h56);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter MEM_AWIDTH SHALL be: default 10, log2 of memory depth in AXI_DATA_WIDTH words.
REQ-002 Parameter AXI_ID_WIDTH SHALL be: default 8, ID width.
REQ-003 Parameter AXI_LEN_WIDTH SHALL be: default 8, burst length field width.
REQ-004 Parameter AXI_ADDR_WIDTH SHALL be: default 32, byte address width.
REQ-005 Parameter AXI_DATA_WIDTH SHALL be: default 256, data width; a power of two, at least 8.
REQ-006 Port clk SHALL be: input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 Port rst SHALL be: input, 1 bit, reset, asynchronous and active-high.
REQ-008 Write-address ports SHALL be: axi_awvalid in 1; axi_awready out 1; axi_awid in ID; axi_awaddr in ADDR; axi_awlen in LEN.
REQ-009 Write-data ports SHALL be: axi_wvalid in 1; axi_wready out 1; axi_wdata in DATA; axi_wstrb in DATA/8; axi_wlast in 1.
REQ-010 Write-response ports SHALL be: axi_bvalid out 1; axi_bready in 1; axi_bid out ID; axi_bresp out 2.
REQ-011 Read-address ports SHALL be: axi_arvalid in 1; axi_arready out 1; axi_arid in ID; axi_araddr in ADDR; axi_arlen in LEN.
REQ-012 Read-data ports SHALL be: axi_rvalid out 1; axi_rready in 1; axi_rid out ID; axi_rdata out DATA; axi_rresp out 2; axi_rlast out 1.

Function
REQ-013 The block SHALL be an AXI4 INCR-burst responder: size and burst type equal to the full bus width; no size, burst, lock, cache, prot or qos ports.
REQ-014 Word index SHALL be addr >> log2(AXI_DATA_WIDTH/8), taken modulo 2^MEM_AWIDTH; bursts wrap silently at the memory top.
REQ-015 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1).
REQ-016 In W_IDLE, an AW handshake SHALL latch id, word index and len, then go to W_DATA.
REQ-017 In W_DATA, each W handshake SHALL write the bytes enabled by wstrb, then increment the index and decrement the beat count.
REQ-018 The beat with count==0 SHALL move the FSM to W_RESP; the W channel SHALL accept exactly awlen+1 beats.
REQ-019 bresp SHALL be 2'b10 (SLVERR) if wlast was wrong on any beat of the burst, else 2'b00; bid SHALL equal the latched awid.
REQ-020 A B handshake SHALL return the FSM to W_IDLE; W_RESP to W_IDLE SHALL take one cycle.
REQ-021 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA.
REQ-022 An AR handshake SHALL latch id, index and len; one write and one read burst SHALL be outstanding at a time.
REQ-023 Memory reads SHALL be synchronous. The first rvalid SHALL assert exactly 2 cycles after the AR handshake.
REQ-024 While rready stays high, the read path SHALL sustain one beat per cycle without bubbles, using a 2-entry output skid buffer.
REQ-025 When rready is low, rvalid, rdata, rlast and rid SHALL hold stable.
REQ-026 rlast SHALL be high on beat len only; rresp SHALL be 2'b00.
REQ-027 After the rlast handshake, the read FSM SHALL return to R_IDLE, and arready SHALL re-assert on the next cycle.
REQ-028 A read and a write to the same word in the same cycle SHALL return the old data (read-first).
REQ-029 Read and write channels SHALL operate fully concurrently.
REQ-030 awlen=0 and arlen=0 SHALL be legal single-beat bursts.
REQ-031 Maximum length 2^AXI_LEN_WIDTH beats SHALL be supported.

Reset
REQ-032 While rst is high, all outputs SHALL be 0, both FSMs SHALL be in IDLE, and the skid buffer SHALL be empty.
REQ-033 awready and arready SHALL assert on the first clock edge after rst falls.
REQ-034 Reset asserted mid-burst SHALL abort both bursts with no response; memory contents SHALL be left undefined-preserved, not cleared.

Structure
REQ-035 A shared package SHALL hold the AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the FSM state encodings.
REQ-036 Memory SHALL be one sub-module, axi_mem_ram: a simple dual-port RAM with byte write enables, read-first behaviour, 1-cycle registered read and no reset.

Verification
REQ-037 Write awaddr=0x40, awlen=3, wstrb all ones, data 1..4; then read the same range -> bresp=0, rdata 1..4, rlast on beat 3, first rvalid 2 cycles after the AR handshake.
REQ-038 Write with wstrb=0x0000000F over an existing word of all-ones, data 0 -> read returns 0xFF..FF00000000.
REQ-039 Read awlen=7 while rready toggles 1,0,0,1 -> no beat lost or duplicated, and outputs are stable while stalled.
REQ-040 Burst starting at the last word with len=1 -> second beat lands at word 0; wlast on beat 0 of a len=1 burst -> bresp=2'b10.
REQ-041 Simultaneous AR and AW to the same word, with W in the same cycle as the first read -> read returns old data; a following read returns new data.
REQ-042 rst pulsed during beat 2 of a len=7 read -> rvalid=0 immediately, arready=1 the cycle after release, and a new burst completes correctly.
